// File: rtl/carregador_programa_if.sv
// carregador_programa_if: byte-source handshake plus instruction-memory load bus.
interface carregador_programa_if #(parameter int unsigned ADDR_W = 16);
  logic rx_valid, rx_ready, mem_wr, cpu_resetn, done, erro;
  logic [7:0] rx_data;
  logic [15:0] mem_in;
  logic [ADDR_W-1:0] endereco_ext;
  modport master (output rx_valid, rx_data, input rx_ready, mem_wr, mem_in, endereco_ext, cpu_resetn, done, erro);
  modport slave (input rx_valid, rx_data, output rx_ready, mem_wr, mem_in, endereco_ext, cpu_resetn, done, erro);
endinterface

// File: rtl/carregador_programa.sv
// carregador_programa: framed byte-stream loader writing 16-bit words into instruction memory.
// Define CARREGADOR_CHECKSUM_EN to append and verify a running-XOR checksum byte.
module carregador_programa #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int unsigned ADDR_W = 16
) (
  input logic clock,
  input logic reset,
  carregador_programa_if.slave bus
);
  typedef enum logic [3:0] {SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, WRITE, CHK, FIN} state_t;
`ifdef CARREGADOR_CHECKSUM_EN
  localparam state_t END_S = CHK;
`else
  localparam state_t END_S = FIN;
`endif
  localparam logic FIN_NEXT = (END_S == FIN);
  state_t state_q;
  logic rdy_q, wr_q, rstn_q, done_q, hs;
  logic [7:0] hi_q;
  logic [15:0] din_q;
  logic [ADDR_W-1:0] addr_q, cnt_q, end_q, addr_d, cnt_d;
  assign hs = bus.rx_valid && rdy_q;
  assign addr_d = ADDR_W'({addr_q[7:0], bus.rx_data});
  assign cnt_d = ADDR_W'({cnt_q[7:0], bus.rx_data});
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0] chk_q;
  logic erro_q;
  // Running XOR restarts on every byte seen in SYNC; erro clears only on a new frame start.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      chk_q <= '0;
      erro_q <= 1'b0;
    end else if (hs) begin
      chk_q <= state_q == SYNC ? 8'h00 : chk_q ^ bus.rx_data;
      erro_q <= state_q == SYNC ? (bus.rx_data == SYNC_BYTE ? 1'b0 : erro_q)
              : (state_q == CHK && bus.rx_data != chk_q) ? 1'b1 : erro_q;
    end
  assign bus.erro = erro_q;
`else
  assign bus.erro = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= SYNC;
      rdy_q <= 1'b1;
      wr_q <= 1'b0;
      rstn_q <= 1'b0;
      done_q <= 1'b0;
      hi_q <= '0;
      din_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      end_q <= '0;
    end else begin
      done_q <= 1'b0;
      wr_q <= 1'b0;
      case (state_q)
        SYNC: if (hs && bus.rx_data == SYNC_BYTE) begin
          state_q <= ADDR_H;
          rstn_q <= 1'b0;
        end
        ADDR_H: if (hs) begin
          addr_q <= ADDR_W'(bus.rx_data);
          state_q <= ADDR_L;
        end
        ADDR_L: if (hs) begin
          addr_q <= addr_d;
          state_q <= CNT_H;
        end
        CNT_H: if (hs) begin
          cnt_q <= ADDR_W'(bus.rx_data);
          state_q <= CNT_L;
        end
        CNT_L: if (hs) begin
          cnt_q <= cnt_d;
          state_q <= cnt_d == '0 ? END_S : DATA_H;
          rdy_q <= cnt_d != '0 || !FIN_NEXT;
          done_q <= cnt_d == '0 && FIN_NEXT;
          rstn_q <= cnt_d == '0 && FIN_NEXT;
        end
        DATA_H: if (hs) begin
          hi_q <= bus.rx_data;
          state_q <= DATA_L;
        end
        DATA_L: if (hs) begin
          din_q <= {hi_q, bus.rx_data};
          end_q <= addr_q;
          wr_q <= 1'b1;
          rdy_q <= 1'b0;
          state_q <= WRITE;
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          cnt_q <= cnt_q - 1'b1;
          state_q <= cnt_q == ADDR_W'(1) ? END_S : DATA_H;
          rdy_q <= cnt_q != ADDR_W'(1) || !FIN_NEXT;
          done_q <= cnt_q == ADDR_W'(1) && FIN_NEXT;
          rstn_q <= cnt_q == ADDR_W'(1) && FIN_NEXT;
        end
`ifdef CARREGADOR_CHECKSUM_EN
        CHK: if (hs) begin
          state_q <= bus.rx_data == chk_q ? FIN : SYNC;
          rdy_q <= bus.rx_data != chk_q;
          done_q <= bus.rx_data == chk_q;
          rstn_q <= bus.rx_data == chk_q;
        end
`endif
        default: begin
          state_q <= SYNC;
          rdy_q <= 1'b1;
        end
      endcase
    end
  assign bus.rx_ready = rdy_q;
  assign bus.mem_wr = wr_q;
  assign bus.mem_in = din_q;
  assign bus.endereco_ext = end_q;
  assign bus.cpu_resetn = rstn_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: table of frames with random payloads checked against a frame-level model.
module tb_carregador_programa;
`ifdef CARREGADOR_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  carregador_programa_if #(.ADDR_W(16)) bus ();
  carregador_programa #(.SYNC_BYTE(8'hA5), .ADDR_W(16)) dut (.clock(clk), .reset(rst), .bus(bus));

  typedef struct {
    logic [15:0] addr;
    int n;
    bit fixed;
    logic [15:0] w0, w1;
    bit garbage, stall, bad;
    int exp_done;
    bit exp_rstn, exp_erro;
  } vec_t;
  vec_t vecs[$];
  int errors = 0, checks = 0, done_cnt = 0;
  logic [31:0] got[$];
  logic [31:0] last_wr = '0;
  logic prev_rstn = 1'b0;

  function automatic vec_t mk(input logic [15:0] a, input int n, input bit f, input logic [15:0] w0, w1,
                              input bit g, s, b, input int d, input bit r, e);
    vec_t v;
    v.addr = a; v.n = n; v.fixed = f; v.w0 = w0; v.w1 = w1;
    v.garbage = g; v.stall = s; v.bad = b; v.exp_done = d; v.exp_rstn = r; v.exp_erro = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.mem_wr) got.push_back({bus.endereco_ext, bus.mem_in});
    if (bus.done) begin
      done_cnt++;
      chk("rstn_rises_with_done", {62'd0, prev_rstn, bus.cpu_resetn}, 64'b01);
    end
    chk("ready_low_only_write_fin", bus.rx_ready, !(bus.mem_wr || bus.done));
    prev_rstn = bus.cpu_resetn;
  end

  task automatic send(input logic [7:0] b, input bit stall);
    int g = 0;
    if (stall) while ($urandom_range(0, 2) == 0) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    while (!bus.rx_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: rx_ready stayed 0 for %0d cycles, required 1", g);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] fr[$];
    logic [31:0] exp[$];
    logic [7:0] x = 8'h00;
    logic [15:0] w;
    got.delete();
    done_cnt = 0;
    if (v.garbage) begin
      send(8'h00, v.stall);
      send(8'hFF, v.stall);
      send(8'h5A, v.stall);
    end
    fr.push_back(v.addr[15:8]);
    fr.push_back(v.addr[7:0]);
    fr.push_back(8'(v.n >> 8));
    fr.push_back(8'(v.n));
    for (int i = 0; i < v.n; i++) begin
      w = (v.fixed && i == 0) ? v.w0 : (v.fixed && i == 1) ? v.w1 : 16'($urandom);
      fr.push_back(w[15:8]);
      fr.push_back(w[7:0]);
      exp.push_back({16'(v.addr + i), w});
    end
    foreach (fr[i]) x ^= fr[i];
    if (CHK_EN) fr.push_back(v.bad ? x ^ 8'h5A : x);
    send(8'hA5, v.stall);
    chk("rstn_low_after_sync", bus.cpu_resetn, 0);
    foreach (fr[i]) begin
      send(fr[i], v.stall);
      if (i >= 5 && i < 4 + 2 * v.n && i % 2 == 1) chk("wr_after_data_l", bus.mem_wr, 1);
    end
    repeat (4) @(negedge clk);
    chk("n_writes", got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) chk("write_addr_data", got[i], exp[i]);
    chk("done_pulses", done_cnt, v.exp_done);
    chk("cpu_resetn", bus.cpu_resetn, v.exp_rstn);
    chk("erro", bus.erro, v.exp_erro);
    if (exp.size() > 0) last_wr = exp[$];
    chk("outputs_hold", {bus.endereco_ext, bus.mem_in}, last_wr);
  endtask

  task automatic chk_reset(input string name);
    chk(name, {bus.rx_ready, bus.mem_wr, bus.mem_in, bus.endereco_ext, bus.cpu_resetn, bus.done, bus.erro},
        {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    vecs.push_back(mk(16'h0010, 2, 1, 16'h1234, 16'hABCD, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(16'hFFFF, 2, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(16'h0010, 2, 1, 16'h1234, 16'hABCD, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(16'h0100, 5, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(16'h0020, 2, 1, 16'hA5A5, 16'h00A5, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(16'hFFFE, 4, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 0));
    if (CHK_EN) begin
      vecs.push_back(mk(16'h0010, 1, 1, 16'h1234, 16'h0000, 0, 0, 1, 0, 0, 1));
      vecs.push_back(mk(16'h0040, 3, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 0));
    end
    #1 rst = 1'b1;
    #1 chk_reset("async_reset_values");
    repeat (2) @(negedge clk);
    chk_reset("reset_held_values");
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run_frame(vecs[i]);
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h10, 0);
    #2 rst = 1'b1;
    #1 chk_reset("mid_frame_reset_values");
    last_wr = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(vecs[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
